// File: rtl/sensor_conditioner_pkg.sv
// sensor_conditioner_pkg: level codes, fault FSM states and level validity check
package sensor_conditioner_pkg;
    localparam logic [2:0] NIVEL_VAZIO = 3'b000;
    localparam logic [2:0] NIVEL_BAIXO = 3'b001;
    localparam logic [2:0] NIVEL_MEDIO = 3'b011;
    localparam logic [2:0] NIVEL_CHEIO = 3'b111;
    typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULT} fault_state_t;
    function automatic logic nivel_valido(input logic [2:0] n);
        return n == NIVEL_VAZIO || n == NIVEL_BAIXO || n == NIVEL_MEDIO || n == NIVEL_CHEIO;
    endfunction
endpackage

// File: rtl/sensor_conditioner_debounce_bit.sv
// sensor_conditioner_debounce_bit: 2-flop synchroniser plus sample-driven debounce of one binary pin
// Ports: clk_i/rst_ni clock and async active-low reset, raw_i raw pin, sample_en_i sample strobe,
//        filt_o debounced value, upd_o high in the cycle filt_o is about to change
module sensor_conditioner_debounce_bit #(
    parameter int STABLE_TICKS = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    input  logic sample_en_i,
    output logic filt_o,
    output logic upd_o
);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
    logic [1:0] sync_q;
    logic filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end
    // The counter is cleared whenever it reaches the limit, so it never exceeds LAST.
    always_comb begin
        upd_o  = sample_en_i && sync_q[1] != filt_q && cnt_q == LAST;
        filt_d = upd_o ? sync_q[1] : filt_q;
        cnt_d  = !sample_en_i ? cnt_q : (sync_q[1] == filt_q || upd_o) ? '0 : cnt_q + 1'b1;
    end
    assign filt_o = filt_q;
endmodule

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronise, sample and debounce irrigation sensors; filter and police the water level
// Ports: clock, reset_n (async active-low); *_raw field pins; umidade_ar/umidade_solo/temperatura
//        debounced binaries; nivel filtered level (always valid); nivel_erro level fault; mudanca change pulse.
// Optional: define LEVEL_STEP_LIMIT_EN to move nivel by one code step per accepted update.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int SAMPLE_DIV   = 50000,
    parameter int STABLE_TICKS = 8,
    parameter int FAULT_TICKS  = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       umidade_ar_raw,
    input  logic       umidade_solo_raw,
    input  logic       temperatura_raw,
    input  logic [2:0] nivel_raw,
    output logic       umidade_ar,
    output logic       umidade_solo,
    output logic       temperatura,
    output logic [2:0] nivel,
    output logic       nivel_erro,
    output logic       mudanca
);
    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam int FW = $clog2((FAULT_TICKS > STABLE_TICKS ? FAULT_TICKS : STABLE_TICKS) + 1);
    logic [PW-1:0] pre_q, pre_d;
    logic sample_en;
    logic ar_upd, solo_upd, temp_upd;
    logic [2:0] ls1_q, ls2_q, nivel_q, nivel_d, cand_q, cand_d, nivel_alvo;
    logic [CW-1:0] lcnt_q, lcnt_d, lnext;
    logic l_ok, l_hit;
    fault_state_t st_q, st_d;
    logic [FW-1:0] fcnt_q, fcnt_d, fnext;
    logic mudanca_q, mudanca_d;
    sensor_conditioner_debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_ar (
        .clk_i(clock), .rst_ni(reset_n), .raw_i(umidade_ar_raw), .sample_en_i(sample_en),
        .filt_o(umidade_ar), .upd_o(ar_upd));
    sensor_conditioner_debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_solo (
        .clk_i(clock), .rst_ni(reset_n), .raw_i(umidade_solo_raw), .sample_en_i(sample_en),
        .filt_o(umidade_solo), .upd_o(solo_upd));
    sensor_conditioner_debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_temp (
        .clk_i(clock), .rst_ni(reset_n), .raw_i(temperatura_raw), .sample_en_i(sample_en),
        .filt_o(temperatura), .upd_o(temp_upd));
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q     <= '0;
            ls1_q     <= '0;
            ls2_q     <= '0;
            nivel_q   <= NIVEL_VAZIO;
            cand_q    <= NIVEL_VAZIO;
            lcnt_q    <= '0;
            st_q      <= ST_OK;
            fcnt_q    <= '0;
            mudanca_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            ls1_q     <= nivel_raw;
            ls2_q     <= ls1_q;
            nivel_q   <= nivel_d;
            cand_q    <= cand_d;
            lcnt_q    <= lcnt_d;
            st_q      <= st_d;
            fcnt_q    <= fcnt_d;
            mudanca_q <= mudanca_d;
        end
    end
`ifdef LEVEL_STEP_LIMIT_EN
    // Thermometer codes order numerically, so one step up shifts in a 1 and one step down shifts it out.
    assign nivel_alvo = (ls2_q > nivel_q) ? {nivel_q[1:0], 1'b1} : {1'b0, nivel_q[2:1]};
`else
    assign nivel_alvo = ls2_q;
`endif
    // Level debounce: the count continues only while the same valid candidate repeats;
    // a new candidate restarts at 1 and an invalid sample clears it.
    always_comb begin
        sample_en = pre_q == PW'(SAMPLE_DIV - 1);
        pre_d     = sample_en ? '0 : pre_q + 1'b1;
        l_ok      = nivel_valido(ls2_q);
        lnext     = (lcnt_q != '0 && ls2_q == cand_q) ? lcnt_q + 1'b1 : CW'(1);
        l_hit     = sample_en && l_ok && ls2_q != nivel_q && lnext == CW'(STABLE_TICKS);
        cand_d    = sample_en ? ls2_q : cand_q;
        lcnt_d    = !sample_en ? lcnt_q : (!l_ok || ls2_q == nivel_q || l_hit) ? '0 : lnext;
        nivel_d   = l_hit ? nivel_alvo : nivel_q;
    end
    // Fault FSM: fcnt counts consecutive invalid samples in SUSPECT and consecutive valid samples in FAULT.
    always_comb begin
        st_d   = st_q;
        fcnt_d = fcnt_q;
        fnext  = fcnt_q + 1'b1;
        if (sample_en) begin
            case (st_q)
                ST_OK: if (!l_ok) begin
                    st_d   = (FAULT_TICKS <= 1) ? ST_FAULT : ST_SUSPECT;
                    fcnt_d = (FAULT_TICKS <= 1) ? '0 : FW'(1);
                end
                ST_SUSPECT: begin
                    st_d   = l_ok ? ST_OK : (fnext == FW'(FAULT_TICKS)) ? ST_FAULT : ST_SUSPECT;
                    fcnt_d = (l_ok || fnext == FW'(FAULT_TICKS)) ? '0 : fnext;
                end
                ST_FAULT: begin
                    st_d   = (l_ok && fnext == FW'(STABLE_TICKS)) ? ST_OK : ST_FAULT;
                    fcnt_d = (!l_ok || fnext == FW'(STABLE_TICKS)) ? '0 : fnext;
                end
                default: begin
                    st_d   = ST_OK;
                    fcnt_d = '0;
                end
            endcase
        end
        mudanca_d = ar_upd || solo_upd || temp_upd || l_hit || ((st_d == ST_FAULT) != (st_q == ST_FAULT));
    end
    assign nivel      = nivel_q;
    assign nivel_erro = st_q == ST_FAULT;
    assign mudanca    = mudanca_q;
endmodule
